// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: operation encoding and its width.
package stack_pkg;

    localparam int OP_W = 3;

    // Codes 6 and 7 are not named; the stack treats them as NOP.
    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_DUP     = 3'd3,
        OP_SWAP    = 3'd4,
        OP_REPLACE = 3'd5
    } stack_op_t;

endpackage

// File: rtl/stack_regfile.sv
// Storage array for the operand stack.
//   clk              rising-edge clock (array is not reset)
//   we_a/wa_idx/wa_data   write port A (PUSH, DUP, REPLACE, SWAP)
//   we_b/wb_idx/wb_data   write port B (SWAP only)
//   ra_idx/ra_data   combinational read port (top of stack)
//   rb_idx/rb_data   combinational read port (next on stack)
// The two write ports are only ever enabled together for SWAP, where the
// indices differ, so no write-write collision resolution is needed.
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_a,
    input  logic [AW-1:0]    wa_idx,
    input  logic [WIDTH-1:0] wa_data,
    input  logic             we_b,
    input  logic [AW-1:0]    wb_idx,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [AW-1:0]    ra_idx,
    input  logic [AW-1:0]    rb_idx,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[wa_idx] <= wa_data;
        if (we_b) mem[wb_idx] <= wb_data;
    end

    // Reads at indices beyond the valid entries are masked by the top.
    assign ra_data = mem[ra_idx];
    assign rb_data = mem[rb_idx];

endmodule

// File: rtl/stack_unit.sv
// Parametrised operand stack for the multicycle stack-machine datapath.
//   clk, rst (async, active-low)
//   op_valid, op, din       one operation per cycle
//   err_clr                 clears both sticky error flags
//   tos, nos, zero, count, empty, full   live combinational view of the stack
//   pop_data, pop_valid     value removed by the last POP/REPLACE, one-cycle pulse
//   err_ovf, err_unf        sticky overflow / underflow flags
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  stack_op_t        op,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic             zero,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    nxt_idx, top_idx, sec_idx;
    logic [WIDTH-1:0] rd_top, rd_sec;
    logic             has1, has2;
    logic             we_a, we_b;
    logic [AW-1:0]    wa_idx, wb_idx;
    logic [WIDTH-1:0] wa_data, wb_data;
    logic             pop_fire, set_ovf, set_unf;

    // Index arithmetic wraps when count is 0 or 1; the wrapped reads are
    // masked below and no write uses them because the guards reject the op.
    assign nxt_idx = AW'(cnt_q);
    assign top_idx = AW'(cnt_q - CW'(1));
    assign sec_idx = AW'(cnt_q - CW'(2));

    assign has1  = (cnt_q != '0);
    assign has2  = (cnt_q >= CW'(2));
    assign empty = ~has1;
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign tos   = has1 ? rd_top : '0;
    assign nos   = has2 ? rd_sec : '0;
    assign zero  = has1 && (rd_top == '0);

    stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
        .clk     (clk),
        .we_a    (we_a),
        .wa_idx  (wa_idx),
        .wa_data (wa_data),
        .we_b    (we_b),
        .wb_idx  (wb_idx),
        .wb_data (wb_data),
        .ra_idx  (top_idx),
        .rb_idx  (sec_idx),
        .ra_data (rd_top),
        .rb_data (rd_sec)
    );

    // Decode and guard. An op that fails its guard only raises a flag.
    always_comb begin
        we_a     = 1'b0;
        wa_idx   = nxt_idx;
        wa_data  = din;
        we_b     = 1'b0;
        wb_idx   = sec_idx;
        wb_data  = tos;
        cnt_d    = cnt_q;
        pop_fire = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        if (op_valid) begin
            case (op)
                OP_PUSH: begin
                    if (full) set_ovf = 1'b1;
                    else begin
                        we_a  = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (!has1) set_unf = 1'b1;
                    else begin
                        pop_fire = 1'b1;
                        cnt_d    = cnt_q - CW'(1);
                    end
                end
                OP_DUP: begin
                    // Empty takes precedence over full.
                    if (!has1) set_unf = 1'b1;
                    else if (full) set_ovf = 1'b1;
                    else begin
                        we_a    = 1'b1;
                        wa_data = tos;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has2) set_unf = 1'b1;
                    else begin
                        we_a    = 1'b1;
                        wa_idx  = top_idx;
                        wa_data = nos;
                        we_b    = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    if (!has1) set_unf = 1'b1;
                    else begin
                        we_a     = 1'b1;
                        wa_idx   = top_idx;
                        pop_fire = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pop_valid <= pop_fire;
            if (pop_fire) pop_data <= tos;
            // A new error in the same cycle as err_clr keeps the flag set.
            err_ovf   <= set_ovf | (err_ovf & ~err_clr);
            err_unf   <= set_unf | (err_unf & ~err_clr);
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;
    import stack_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             op_valid;
    stack_op_t        op;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [WIDTH-1:0] tos, nos, pop_data;
    logic             zero, empty, full, pop_valid, err_ovf, err_unf;
    logic [CW-1:0]    count;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
        .err_clr(err_clr), .tos(tos), .nos(nos), .zero(zero), .count(count),
        .empty(empty), .full(full), .pop_data(pop_data), .pop_valid(pop_valid),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tos, nos, cnt, pd;
        bit zero, empty, full, pv, ovf, unf;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   pop_q[$];

    // Reference model: the stack as a queue, top at the back.
    int stk[$];
    bit m_ovf, m_unf;
    int m_pd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t snap(input bit pv);
        exp_t e;
        int n = stk.size();
        e.cnt   = n;
        e.tos   = (n > 0) ? stk[n-1] : 0;
        e.nos   = (n > 1) ? stk[n-2] : 0;
        e.zero  = (n > 0) && (e.tos == 0);
        e.empty = (n == 0);
        e.full  = (n == DEPTH);
        e.pv    = pv;
        e.pd    = m_pd;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic cmp_state(input exp_t e);
        chk("count", 32'(count), e.cnt);
        chk("tos", 32'(tos), e.tos);
        chk("nos", 32'(nos), e.nos);
        chk("zero", 32'(zero), 32'(e.zero));
        chk("empty", 32'(empty), 32'(e.empty));
        chk("full", 32'(full), 32'(e.full));
        chk("pop_valid", 32'(pop_valid), 32'(e.pv));
        chk("pop_data", 32'(pop_data), e.pd);
        chk("err_ovf", 32'(err_ovf), 32'(e.ovf));
        chk("err_unf", 32'(err_unf), 32'(e.unf));
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf = 0; m_unf = 0; m_pd = 0;
    endtask

    // Issue one cycle of stimulus and record what the stack must look like after it.
    task automatic do_op(input bit v, input int code, input int d, input bit clr);
        bit eo, eu, pv;
        int n, t;
        logic [2:0] c3;
        c3 = code[2:0];
        @(negedge clk);
        op_valid = v; op = stack_op_t'(c3); din = d[7:0]; err_clr = clr;
        @(posedge clk);
        #1;
        eo = 0; eu = 0; pv = 0; n = stk.size();
        if (v) begin
            case (code)
                1: if (n == DEPTH) eo = 1; else stk.push_back(d & 8'hFF);
                2: if (n == 0) eu = 1; else begin m_pd = stk.pop_back(); pv = 1; end
                3: if (n == 0) eu = 1; else if (n == DEPTH) eo = 1; else stk.push_back(stk[n-1]);
                4: if (n < 2) eu = 1;
                   else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
                5: if (n == 0) eu = 1; else begin m_pd = stk[n-1]; stk[n-1] = d & 8'hFF; pv = 1; end
                default: ;
            endcase
        end
        m_ovf = eo | (m_ovf & !clr);
        m_unf = eu | (m_unf & !clr);
        if (pv) pop_q.push_back(m_pd);
        exp_q.push_back(snap(pv));
        op_valid = 0; err_clr = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count", 32'(count), 0);
        chk("rst_tos", 32'(tos), 0);
        chk("rst_nos", 32'(nos), 0);
        chk("rst_zero", 32'(zero), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_pop_valid", 32'(pop_valid), 0);
        chk("rst_pop_data", 32'(pop_data), 0);
        chk("rst_err_ovf", 32'(err_ovf), 0);
        chk("rst_err_unf", 32'(err_unf), 0);
    endtask

    // Monitor: compares the DUT view after every issued op, and every
    // pop_valid pulse against the queue of values the model removed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp_state(e);
            end
            if (pop_valid === 1'b1) begin
                if (pop_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_unexpected: got pulse with %0h expected none", pop_data);
                end else begin
                    chk("pop_sb", 32'(pop_data), pop_q.pop_front());
                end
            end
        end
    end

    initial begin
        int r, code, d;
        rst = 1'b0; op_valid = 0; op = OP_NOP; din = '0; err_clr = 0;
        model_reset();
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic push/pop.
        do_op(1, 1, 'h11, 0); do_op(1, 1, 'h22, 0); do_op(1, 1, 'h33, 0);
        do_op(1, 2, 0, 0);
        do_op(0, 0, 0, 0);
        do_op(1, 2, 0, 0); do_op(1, 2, 0, 0);

        // Fill and overflow, then clear.
        for (int i = 0; i < 5; i++) do_op(1, 1, 'h40 + i, 0);
        do_op(1, 3, 0, 0);               // DUP when full
        do_op(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) do_op(1, 2, 0, 0);

        // Underflow cases.
        do_op(1, 2, 0, 0);               // POP empty
        do_op(1, 3, 0, 1);               // DUP empty with clear: unf stays
        do_op(0, 0, 0, 1);
        do_op(1, 1, 'h77, 0);
        do_op(1, 4, 0, 0);               // SWAP with one entry
        for (int i = 0; i < 4; i++) do_op(1, 1, 'h60 + i, 0);   // last overflows
        for (int i = 0; i < 4; i++) do_op(1, 2, 0, 0);
        do_op(1, 2, 0, 1);               // clear + new unf: unf=1, ovf=0
        do_op(1, 5, 'h12, 0);            // REPLACE empty
        do_op(0, 0, 0, 1);

        // Zero flag, SWAP, DUP, REPLACE.
        do_op(1, 1, 'h05, 0); do_op(1, 1, 'h00, 0);
        do_op(1, 4, 0, 0);
        do_op(1, 3, 0, 0);
        do_op(1, 5, 'hAA, 0);
        do_op(1, 6, 'h99, 0); do_op(1, 7, 'h99, 0);   // unnamed codes act as NOP

        // Asynchronous reset mid-stream during a pop_valid pulse with err_ovf set.
        do_op(1, 1, 'h01, 0); do_op(1, 1, 'h02, 0);   // second overflows
        do_op(1, 2, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2: code = 1;
                3, 4:    code = 2;
                5:       code = 3;
                6:       code = 4;
                7:       code = 5;
                8:       code = 0;
                9:       code = $urandom_range(6, 7);
                default: code = $urandom_range(1, 2);
            endcase
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            do_op($urandom_range(0, 7) != 0, code, d, $urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("pop_q_drained", 32'(pop_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
